// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin front end for busmaster; one owner at a time,
// tenure capped at MAX_BURST words, owner's request/data/id muxed onto bm_*.
module bus_rr_arbiter #(
    parameter int N = 4,
    parameter int DW = 32,
    parameter int IW = 4,
    parameter int MAX_BURST = 8,
    localparam int CW = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            bm_grant,
    input  logic [N-1:0]    req,
    input  logic [N*DW-1:0] dev_data,
    input  logic [N*IW-1:0] dev_id,
    output logic [N-1:0]    gnt,
    output logic            bm_request,
    output logic [DW-1:0]   bm_data,
    output logic [IW-1:0]   bm_id,
    output logic [CW-1:0]   owner,
    output logic            busy
);
    localparam int BW = $clog2(MAX_BURST + 1);
    typedef enum logic {IDLE, OWN} state_t;
    state_t state;
    logic [CW-1:0] last, win, idx;
    logic [BW-1:0] cnt;
    logic found, done;
    // Scan from farthest to nearest so the first requester after last wins.
    always_comb begin
        win = '0;
        idx = '0;
        found = 1'b0;
        for (int k = N; k >= 1; k--) begin
            idx = CW'((int'(last) + k) % N);
            if (req[idx]) begin
                win = idx;
                found = 1'b1;
            end
        end
    end
    assign done = !req[owner] || !bm_grant || cnt == BW'(MAX_BURST - 1);
    assign busy = state == OWN;
    assign bm_request = busy && req[owner];
    assign bm_data = busy ? dev_data[owner*DW +: DW] : '0;
    assign bm_id = busy ? dev_id[owner*IW +: IW] : '0;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            owner <= '0;
            last <= CW'(N - 1);
            cnt <= '0;
            gnt <= '0;
        end else if (state == OWN) begin
            if (done) begin
                state <= IDLE;
                last <= owner;
                gnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else if (bm_grant && found) begin
            state <= OWN;
            owner <= win;
            cnt <= '0;
            gnt <= N'(1) << win;
        end
    end
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb_bus_rr_arbiter: directed stimulus; a word-counting arbitration model is
// compared against the DUT every falling edge, plus hand-computed spot checks.
module tb_bus_rr_arbiter;
    localparam int N = 4;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int MB = 8;
    localparam int CW = $clog2(N);

    logic            clk;
    logic            reset;
    logic            bm_grant;
    logic [N-1:0]    req;
    logic [N*DW-1:0] dev_data;
    logic [N*IW-1:0] dev_id;
    logic [N-1:0]    gnt;
    logic            bm_request;
    logic [DW-1:0]   bm_data;
    logic [IW-1:0]   bm_id;
    logic [CW-1:0]   owner;
    logic            busy;

    int passed = 0;
    int total = 0;

    bus_rr_arbiter #(.N(N), .DW(DW), .IW(IW), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset), .bm_grant(bm_grant), .req(req),
        .dev_data(dev_data), .dev_id(dev_id), .gnt(gnt),
        .bm_request(bm_request), .bm_data(bm_data), .bm_id(bm_id),
        .owner(owner), .busy(busy)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: who owns the bus and how many words it has moved this tenure.
    bit m_own = 0;
    int m_owner = 0;
    int m_last = N - 1;
    int m_words = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_own = 0;
            m_owner = 0;
            m_last = N - 1;
            m_words = 0;
        end else if (m_own) begin
            if (req[m_owner] && bm_grant) m_words++;
            if (!req[m_owner] || !bm_grant || m_words == MB) begin
                m_own = 0;
                m_last = m_owner;
            end
        end else if (bm_grant && req != 0) begin
            for (int k = 1; k <= N; k++) begin
                if (req[(m_last + k) % N]) begin
                    m_owner = (m_last + k) % N;
                    break;
                end
            end
            m_own = 1;
            m_words = 0;
        end
    end

    always @(negedge clk) begin
        chk("model_gnt", gnt, m_own ? (64'd1 << m_owner) : 64'd0);
        chk("model_bm_request", bm_request, m_own && req[m_owner]);
        chk("model_bm_data", bm_data, m_own ? dev_data[m_owner*DW +: DW] : '0);
        chk("model_bm_id", bm_id, m_own ? dev_id[m_owner*IW +: IW] : '0);
        chk("model_busy", busy, m_own);
        if (m_own) chk("model_owner", owner, m_owner);
    end

    logic [N-1:0] g [0:44];
    int nreq;

    initial begin
        reset = 0;
        bm_grant = 1;
        req = 4'($urandom);
        for (int i = 0; i < N; i++) begin
            dev_data[i*DW +: DW] = 32'hCAFE0000 | i;
            dev_id[i*IW +: IW] = IW'(i);
        end
        #3;
        chk("rst_gnt", gnt, 0);
        chk("rst_bm_request", bm_request, 0);
        chk("rst_bm_data", bm_data, 0);
        chk("rst_bm_id", bm_id, 0);
        chk("rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        req = 4'b1111;
        tick();
        chk("first_win_dev0", gnt, 4'b0001);
        // Full contention rotation.
        g[0] = gnt;
        nreq = bm_request;
        for (int c = 1; c < 45; c++) begin
            tick();
            g[c] = gnt;
            if (c < 36) nreq += bm_request;
        end
        chk("rot_c7", g[7], 4'b0001);
        chk("rot_gap8", g[8], 4'b0000);
        chk("rot_c9", g[9], 4'b0010);
        chk("rot_gap17", g[17], 4'b0000);
        chk("rot_c18", g[18], 4'b0100);
        chk("rot_c27", g[27], 4'b1000);
        chk("rot_gap35", g[35], 4'b0000);
        chk("rot_wrap36", g[36], 4'b0001);
        chk("rot_words", nreq, 32);
        req = 4'b0000;
        tick();
        chk("idle_after_rot", gnt, 4'b0000);
        // Single requester, with a non-owner's data wiggling underneath.
        req = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            dev_data[0 +: DW] = $urandom;
            chk("single_gnt", gnt, 4'b0100);
            chk("single_req", bm_request, 1);
            chk("single_data", bm_data, 32'hCAFE0002);
            chk("single_id", bm_id, 4'h2);
        end
        tick();
        req = 4'b0000;
        tick();
        chk("single_release", gnt, 4'b0000);
        // Backpressure on device 1 after three words.
        req = 4'b0010;
        tick();
        req = 4'b1010;
        chk("bp_own_dev1", gnt, 4'b0010);
        repeat (3) tick();
        bm_grant = 0;
        #1;
        chk("bp_still_own", gnt, 4'b0010);
        tick();
        chk("bp_drop", gnt, 4'b0000);
        chk("bp_busy", busy, 0);
        tick();
        chk("bp_hold", gnt, 4'b0000);
        bm_grant = 1;
        tick();
        chk("bp_resume_dev3", gnt, 4'b1000);
        // Fairness: device 3 steps aside, device 1 returns and re-wins alone.
        req = 4'b0010;
        tick();
        chk("fair_gap", gnt, 4'b0000);
        tick();
        chk("fair_dev1", gnt, 4'b0010);
        for (int r = 1; r < 10; r++) begin
            tick();
            g[r] = gnt;
        end
        chk("fair_last_word", g[7], 4'b0010);
        chk("fair_regap", g[8], 4'b0000);
        chk("fair_regrant", g[9], 4'b0010);
        // Reset in the middle of device 2's tenure.
        req = 4'b0100;
        tick();
        tick();
        chk("mid_dev2", gnt, 4'b0100);
        tick();
        #2;
        reset = 0;
        #1;
        chk("mid_rst_gnt", gnt, 0);
        chk("mid_rst_bm_request", bm_request, 0);
        chk("mid_rst_bm_data", bm_data, 0);
        chk("mid_rst_bm_id", bm_id, 0);
        chk("mid_rst_busy", busy, 0);
        req = 4'b1100;
        @(posedge clk);
        #1;
        reset = 1;
        tick();
        chk("post_rst_dev2", gnt, 4'b0100);
        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
